// File: rtl/commit_unit_pkg.sv
// commit_unit shared types
// ROB head entry, store-buffer entry and drain FSM state
package commit_unit_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] npc;
    logic [31:0]     inst;
    logic            wr_mem;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] dest_addr;
    logic [XLEN-1:0] value;
    logic [2:0]      mem_size;
  } ROB_ENTRY;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      size;
  } SB_ENTRY;

  typedef enum logic {
    SB_IDLE,
    SB_REQ
  } SB_STATE;

  function automatic logic same_word(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    return a[XLEN-1:2] == b[XLEN-1:2];
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// commit_unit data-memory store port
// master = store buffer, slave = memory
interface commit_unit_if;
  import commit_unit_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data;
  logic [2:0]      mem_size;
  logic            mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_data,
    output mem_size,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    input  mem_size,
    output mem_ack
  );

endinterface

// File: rtl/commit_unit_store_buffer.sv
// Post-commit store buffer: circular FIFO, drain FSM
// and same-word conflict lookup for the load path
module store_buffer
  import commit_unit_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int PW = $clog2(SB_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            push_i,
  input  SB_ENTRY         push_entry_i,
  commit_unit_if.master   mem,
  input  logic [XLEN-1:0] ld_check_addr_i,
  output logic            ld_conflict_o,
  output logic            full_o,
  output logic [CW-1:0]   count_o
);

  SB_ENTRY       buf_q [SB_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  SB_STATE       state_q, state_d;
  logic          pop;
  logic [PW-1:0] off;

  assign pop     = (state_q == SB_REQ) && mem.mem_ack;
  assign head_d  = pop    ? head_q + PW'(1) : head_q;
  assign tail_d  = push_i ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(push_i) - CW'(pop);
  assign full_o  = count_q == CW'(SB_DEPTH);
  assign count_o = count_q;

  // Entry storage; stale slots are masked by count
  always_ff @(posedge clock) begin
    if (push_i) buf_q[tail_q] <= push_entry_i;
  end

  // Pointers, occupancy and drain state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= SB_IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Drain next-state: hold request until ack empties us
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_IDLE: if (count_q != '0) state_d = SB_REQ;
      SB_REQ:  if (pop && count_d == '0) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  // Request outputs, zero when idle
  always_comb begin
    mem.mem_req  = state_q == SB_REQ;
    mem.mem_addr = '0;
    mem.mem_data = '0;
    mem.mem_size = '0;
    if (state_q == SB_REQ) begin
      mem.mem_addr = buf_q[head_q].addr;
      mem.mem_data = buf_q[head_q].data;
      mem.mem_size = buf_q[head_q].size;
    end
  end

  // Conflict lookup over occupied slots, popping one included
  always_comb begin
    ld_conflict_o = 1'b0;
    off = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (CW'(off) < count_q &&
          same_word(buf_q[i].addr, ld_check_addr_i))
        ld_conflict_o = 1'b1;
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Retire stage: RF writeback, store hand-off
// to the post-commit buffer, retire counter
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  ROB_ENTRY               head_entry,
  input  logic                   head_ready,
  input  logic [ROB_TAG_LEN-1:0] head_tag,
  output logic                   commit_stall,
  output logic                   rf_wr_en,
  output logic [4:0]             rf_wr_idx,
  output logic [XLEN-1:0]        rf_wr_data,
  output logic [ROB_TAG_LEN-1:0] rf_wr_tag,
  commit_unit_if.master          mem,
  input  logic [XLEN-1:0]        ld_check_addr,
  output logic                   ld_conflict,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic [63:0]            retired_count
);

  logic                   sb_full;
  logic                   retire;
  logic                   st_push;
  logic                   rf_upd;
  SB_ENTRY                push_entry;

  logic                   rf_en_q, rf_en_d;
  logic [4:0]             rf_idx_q;
  logic [XLEN-1:0]        rf_data_q;
  logic [ROB_TAG_LEN-1:0] rf_tag_q;
  logic [63:0]            retired_q, retired_d;

  assign commit_stall = sb_full && head_entry.wr_mem;
  assign retire  = head_entry.valid && head_ready && !commit_stall;
  assign st_push = retire && head_entry.wr_mem;
  assign rf_upd  = retire && !head_entry.wr_mem;
  assign rf_en_d = rf_upd && (head_entry.dest_reg != ZERO_REG);
  assign retired_d = retired_q + 64'(retire);

  assign push_entry.addr = head_entry.dest_addr;
  assign push_entry.data = head_entry.value;
  assign push_entry.size = head_entry.mem_size;

  // Registered RF writeback and retire counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_en_q   <= 1'b0;
      rf_idx_q  <= '0;
      rf_data_q <= '0;
      rf_tag_q  <= '0;
      retired_q <= '0;
    end else begin
      rf_en_q   <= rf_en_d;
      retired_q <= retired_d;
      if (rf_upd) begin
        rf_idx_q  <= head_entry.dest_reg;
        rf_data_q <= head_entry.value;
        rf_tag_q  <= head_tag;
      end
    end
  end

  assign rf_wr_en      = rf_en_q;
  assign rf_wr_idx     = rf_idx_q;
  assign rf_wr_data    = rf_data_q;
  assign rf_wr_tag     = rf_tag_q;
  assign retired_count = retired_q;

  store_buffer #(
    .SB_DEPTH(SB_DEPTH)
  ) u_sb (
    .clock          (clock),
    .reset_n        (reset_n),
    .push_i         (st_push),
    .push_entry_i   (push_entry),
    .mem            (mem),
    .ld_check_addr_i(ld_check_addr),
    .ld_conflict_o  (ld_conflict),
    .full_o         (sb_full),
    .count_o        (sb_count)
  );

endmodule

// File: tb/tb_commit_unit.sv
// commit_unit bench: scoreboard of committed
// stores vs. memory-port handshakes
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  ROB_ENTRY               head_entry;
  logic                   head_ready;
  logic [ROB_TAG_LEN-1:0] head_tag;
  logic                   commit_stall;
  logic                   rf_wr_en;
  logic [4:0]             rf_wr_idx;
  logic [XLEN-1:0]        rf_wr_data;
  logic [ROB_TAG_LEN-1:0] rf_wr_tag;
  logic [XLEN-1:0]        ld_check_addr;
  logic                   ld_conflict;
  logic [2:0]             sb_count;
  logic [63:0]            retired_count;

  commit_unit_if mem_if ();

  int      n_chk = 0;
  int      n_err = 0;
  int      ack_mode = 0;
  SB_ENTRY sb_q[$];
  SB_ENTRY exp_e;

  always #5 clock = ~clock;

  commit_unit #(.SB_DEPTH(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .head_entry   (head_entry),
    .head_ready   (head_ready),
    .head_tag     (head_tag),
    .commit_stall (commit_stall),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_idx    (rf_wr_idx),
    .rf_wr_data   (rf_wr_data),
    .rf_wr_tag    (rf_wr_tag),
    .mem          (mem_if.master),
    .ld_check_addr(ld_check_addr),
    .ld_conflict  (ld_conflict),
    .sb_count     (sb_count),
    .retired_count(retired_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory side: ack policy sampled at the edge, applied #1 later
  initial begin
    int m;
    mem_if.mem_ack = 1'b0;
    forever begin
      @(posedge clock);
      m = ack_mode;
      #1;
      case (m)
        1:       mem_if.mem_ack = 1'b1;
        2:       mem_if.mem_ack = ($urandom_range(0, 2) == 0);
        default: mem_if.mem_ack = 1'b0;
      endcase
    end
  end

  // Scoreboard: each accepted request must match the oldest store
  always @(negedge clock) begin
    if (reset_n && mem_if.mem_req && mem_if.mem_ack) begin
      chk("mem_pending", 64'(sb_q.size() != 0), 64'h1);
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        chk("mem_addr", 64'(mem_if.mem_addr), 64'(exp_e.addr));
        chk("mem_data", 64'(mem_if.mem_data), 64'(exp_e.data));
        chk("mem_size", 64'(mem_if.mem_size), 64'(exp_e.size));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_head();
    head_entry = '0;
    head_ready = 1'b0;
    head_tag   = '0;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic [31:0] v,
                           input logic [4:0] tag);
    head_entry          = '0;
    head_entry.valid    = 1'b1;
    head_entry.dest_reg = rd;
    head_entry.value    = v;
    head_tag            = tag;
    head_ready          = 1'b1;
    step();
    idle_head();
  endtask

  task automatic issue_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] sz);
    int      tries;
    SB_ENTRY e;
    tries = 0;
    head_entry           = '0;
    head_entry.valid     = 1'b1;
    head_entry.wr_mem    = 1'b1;
    head_entry.dest_addr = a;
    head_entry.value     = d;
    head_entry.mem_size  = sz;
    head_ready           = 1'b1;
    #1;
    while (commit_stall && tries < 200) begin
      step();
      tries++;
    end
    if (tries >= 200) chk("store_timeout", 64'(commit_stall), 64'h0);
    e.addr = a;
    e.data = d;
    e.size = sz;
    sb_q.push_back(e);
    step();
    idle_head();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb_count != 0 || mem_if.mem_req) && n < 500) begin
      step();
      n++;
    end
    chk(tag, 64'(sb_count), 64'h0);
  endtask

  initial begin
    int n;
    // Reset with garbage on the inputs
    head_entry           = '0;
    head_entry.valid     = 1'b1;
    head_entry.wr_mem    = 1'b1;
    head_entry.dest_reg  = 5'd9;
    head_entry.dest_addr = $urandom();
    head_entry.value     = $urandom();
    head_ready           = 1'b1;
    head_tag             = 5'd17;
    ld_check_addr        = $urandom();
    ack_mode             = 1;
    repeat (3) step();
    chk("rst_rf_en",   64'(rf_wr_en),       64'h0);
    chk("rst_rf_idx",  64'(rf_wr_idx),      64'h0);
    chk("rst_rf_data", 64'(rf_wr_data),     64'h0);
    chk("rst_rf_tag",  64'(rf_wr_tag),      64'h0);
    chk("rst_req",     64'(mem_if.mem_req), 64'h0);
    chk("rst_addr",    64'(mem_if.mem_addr), 64'h0);
    chk("rst_count",   64'(sb_count),       64'h0);
    chk("rst_retired", retired_count,       64'h0);
    chk("rst_confl",   64'(ld_conflict),    64'h0);
    chk("rst_stall",   64'(commit_stall),   64'h0);
    idle_head();
    ack_mode = 0;
    reset_n  = 1'b1;
    repeat (2) step();

    // First ALU retire
    issue_alu(5'd5, 32'h1234, 5'd3);
    chk("add_en",      64'(rf_wr_en),   64'h1);
    chk("add_idx",     64'(rf_wr_idx),  64'h5);
    chk("add_data",    64'(rf_wr_data), 64'h1234);
    chk("add_tag",     64'(rf_wr_tag),  64'h3);
    chk("add_retired", retired_count,   64'h1);
    step();
    chk("add_pulse",   64'(rf_wr_en),   64'h0);

    // Store then write to x0
    issue_store(32'h100, 32'hAA, 3'd2);
    chk("st_no_rf",    64'(rf_wr_en),       64'h0);
    chk("st_count",    64'(sb_count),       64'h1);
    chk("st_req_late", 64'(mem_if.mem_req), 64'h0);
    issue_alu(5'd0, 32'h55, 5'd7);
    chk("x0_no_rf",    64'(rf_wr_en),  64'h0);
    chk("x0_tag",      64'(rf_wr_tag), 64'h7);
    chk("x0_retired",  retired_count,  64'h3);
    n = 0;
    while (!mem_if.mem_req && n < 20) begin
      step();
      n++;
    end
    chk("st_req",  64'(mem_if.mem_req),  64'h1);
    chk("st_addr", 64'(mem_if.mem_addr), 64'h100);
    chk("st_data", 64'(mem_if.mem_data), 64'hAA);
    repeat (2) step();
    chk("st_hold", 64'(mem_if.mem_addr), 64'h100);
    ack_mode = 1;
    wait_drain("st_drain");

    // Fill to capacity with no acks
    ack_mode = 0;
    repeat (3) step();
    for (int i = 0; i < 4; i++)
      issue_store(32'h200 + 32'(i) * 32'h100, 32'hB0 + 32'(i), 3'd2);
    chk("fill_count", 64'(sb_count), 64'h4);
    head_entry           = '0;
    head_entry.valid     = 1'b1;
    head_entry.wr_mem    = 1'b1;
    head_entry.dest_addr = 32'h600;
    head_entry.value     = 32'hB4;
    head_entry.mem_size  = 3'd2;
    head_ready           = 1'b1;
    #1;
    chk("full_stall", 64'(commit_stall), 64'h1);
    step();
    chk("full_stall2", 64'(commit_stall), 64'h1);
    chk("full_noret",  retired_count,     64'h7);
    issue_alu(5'd6, 32'h66, 5'd9);
    chk("full_alu_en",  64'(rf_wr_en),  64'h1);
    chk("full_alu_idx", 64'(rf_wr_idx), 64'h6);

    // Drain from full, queued store waits for the first pop
    head_entry.valid     = 1'b1;
    head_entry.wr_mem    = 1'b1;
    head_entry.dest_addr = 32'h600;
    head_entry.value     = 32'hB4;
    head_entry.mem_size  = 3'd2;
    head_ready           = 1'b1;
    ack_mode             = 1;
    step();
    chk("drn_stall1", 64'(commit_stall), 64'h1);
    chk("drn_cnt1",   64'(sb_count),     64'h4);
    step();
    chk("drn_cnt2",   64'(sb_count),     64'h3);
    chk("drn_stall2", 64'(commit_stall), 64'h0);
    exp_e.addr = 32'h600;
    exp_e.data = 32'hB4;
    exp_e.size = 3'd2;
    sb_q.push_back(exp_e);
    step();
    idle_head();
    chk("drn_cnt3",   64'(sb_count),     64'h3);
    chk("drn_ret",    retired_count,     64'h9);
    wait_drain("drn_empty");
    step();
    chk("drn_idle",   64'(mem_if.mem_req), 64'h0);

    // Load conflict lookup
    ack_mode = 0;
    repeat (3) step();
    issue_store(32'h200, 32'h55, 3'd2);
    ld_check_addr = 32'h202;
    #1;
    chk("cf_hit",  64'(ld_conflict), 64'h1);
    ld_check_addr = 32'h204;
    #1;
    chk("cf_miss", 64'(ld_conflict), 64'h0);
    ld_check_addr = 32'h202;
    ack_mode = 1;
    wait_drain("cf_drain");
    chk("cf_gone", 64'(ld_conflict), 64'h0);

    // Ten stores across pointer wrap, random ack delays
    ack_mode = 2;
    for (int i = 0; i < 10; i++)
      issue_store(32'h1000 + 32'(i) * 32'h10, $urandom(), 3'(i % 3));
    wait_drain("wrap_drain");
    chk("wrap_sb_empty", 64'(sb_q.size()), 64'h0);

    // Reset during an outstanding request
    ack_mode = 0;
    repeat (3) step();
    issue_store(32'h3000, 32'h1, 3'd2);
    issue_store(32'h3004, 32'h2, 3'd2);
    ld_check_addr = 32'h3000;
    n = 0;
    while (!mem_if.mem_req && n < 20) begin
      step();
      n++;
    end
    chk("mr_req_up", 64'(mem_if.mem_req), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("mr_req",     64'(mem_if.mem_req), 64'h0);
    chk("mr_count",   64'(sb_count),       64'h0);
    chk("mr_retired", retired_count,       64'h0);
    chk("mr_confl",   64'(ld_conflict),    64'h0);
    sb_q.delete();
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("mr_idle",    64'(mem_if.mem_req), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
